// File: rtl/bin2c_pkg.sv
// Shared constants and pattern helpers for the two's-complement negator.
package bin2c_pkg;

  localparam int unsigned BIN2C_DEFAULT_WIDTH = 4;
  localparam int unsigned BIN2C_MAX_WIDTH     = 64;

  // 1 followed by width-1 zeros, right-aligned in a max-width word.
  function automatic logic [BIN2C_MAX_WIDTH-1:0] bin2c_most_neg(input int unsigned width);
    logic [BIN2C_MAX_WIDTH-1:0] v;
    v = BIN2C_MAX_WIDTH'(1) << (width - 1);
    return v;
  endfunction

  // 0 followed by width-1 ones, right-aligned in a max-width word.
  function automatic logic [BIN2C_MAX_WIDTH-1:0] bin2c_most_pos(input int unsigned width);
    logic [BIN2C_MAX_WIDTH-1:0] v;
    v = (BIN2C_MAX_WIDTH'(1) << (width - 1)) - BIN2C_MAX_WIDTH'(1);
    return v;
  endfunction

endpackage

// File: rtl/binary_twos_complement_if.sv
// Operand/result bundle for binary_twos_complement.
interface binary_twos_complement_if
  import bin2c_pkg::*;
#(
  parameter int unsigned WIDTH = BIN2C_DEFAULT_WIDTH
);
  logic [WIDTH-1:0] data;
  logic             in_valid;
  logic [WIDTH-1:0] com_out;
  logic             out_valid;
  logic             ovf;
  logic             zero;

  modport master (
    output data, in_valid,
    input  com_out, out_valid, ovf, zero
  );

  modport slave (
    input  data, in_valid,
    output com_out, out_valid, ovf, zero
  );
endinterface

// File: rtl/twos_comp_core.sv
// Combinational negation, most-negative detect, optional saturation, zero detect.
// Saturation of the most-negative input is enabled by defining BIN2C_SATURATE_EN.
module twos_comp_core
  import bin2c_pkg::*;
#(
  parameter int unsigned WIDTH = BIN2C_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(bin2c_most_neg(WIDTH));
`ifdef BIN2C_SATURATE_EN
  localparam logic [WIDTH-1:0] MOST_POS = WIDTH'(bin2c_most_pos(WIDTH));
`endif

  always_comb begin
    ovf    = (data == MOST_NEG);
    result = ~data + WIDTH'(1);
`ifdef BIN2C_SATURATE_EN
    if (ovf) begin
      result = MOST_POS;
    end
`endif
    zero   = (result == '0);
  end

endmodule

// File: rtl/binary_twos_complement.sv
// Registered two's-complement negator; result registers load on in_valid.
// Build option BIN2C_SATURATE_EN selects saturation of the most-negative input.
module binary_twos_complement
  import bin2c_pkg::*;
#(
  parameter int unsigned WIDTH = BIN2C_DEFAULT_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  binary_twos_complement_if.slave bus
);

  logic [WIDTH-1:0] core_result;
  logic             core_ovf;
  logic             core_zero;

  twos_comp_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .data  (bus.data),
    .result(core_result),
    .ovf   (core_ovf),
    .zero  (core_zero)
  );

  // zero resets high so it agrees with the cleared com_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.com_out   <= '0;
      bus.out_valid <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.zero      <= 1'b1;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.com_out <= core_result;
        bus.ovf     <= core_ovf;
        bus.zero    <= core_zero;
      end
    end
  end

endmodule

// File: tb/tb_binary_twos_complement.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances against an arithmetic (-x mod 2^W) model.
module tb_binary_twos_complement;
  import bin2c_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_twos_complement_if #(.WIDTH(4)) bus4 ();
  binary_twos_complement_if #(.WIDTH(8)) bus8 ();

  binary_twos_complement #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  binary_twos_complement #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

`ifdef BIN2C_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Arithmetic negation modulo 2^w, with the saturating build's special case.
  function automatic int ref_neg(input int x, input int w);
    int m;
    int r;
    m = 1 << w;
    r = (m - x) % m;
    if (SAT && x == m / 2) r = m / 2 - 1;
    return r;
  endfunction

  task automatic test_reset();
    logic [6:0] obs;
    rst = 1'b1;
    bus4.in_valid = 1'b1;
    bus4.data = 4'b0011;
    bus8.in_valid = 1'b1;
    bus8.data = 8'h33;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
      checks++;
      if (obs !== 7'b0010000) begin
        errors++;
        $display("FAIL reset cycle=%0d got={v,ovf,z,com}=%b want=%b", i, obs, 7'b0010000);
      end
    end
    rst = 1'b0;
    bus4.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] ins  [8] = '{4'b0011, 4'b0111, 4'b0011, 4'b1011, 4'b0111, 4'b1100, 4'b1011, 4'b1001};
    logic [3:0] outs [8] = '{4'b1101, 4'b1001, 4'b1101, 4'b0101, 4'b1001, 4'b0100, 4'b0101, 4'b0111};
    logic [6:0] obs;
    for (int i = 0; i < 8; i++) begin
      bus4.data = ins[i];
      bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
      checks++;
      if (obs !== {3'b100, outs[i]}) begin
        errors++;
        $display("FAIL directed in=%b got=%b want=%b", ins[i], obs, {3'b100, outs[i]});
      end
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_most_negative();
    logic [6:0] obs;
    logic [6:0] want;
    want = SAT ? 7'b1100111 : 7'b1101000;
    bus4.data = 4'b1000;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL most_negative got=%b want=%b", obs, want);
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_zero();
    logic [6:0] obs;
    bus4.data = 4'b0000;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
    checks++;
    if (obs !== 7'b1010000) begin
      errors++;
      $display("FAIL zero_input got=%b want=%b", obs, 7'b1010000);
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_hold();
    logic [6:0] obs;
    bus4.data = 4'b0101;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
    checks++;
    if (obs !== 7'b1001011) begin
      errors++;
      $display("FAIL hold_load got=%b want=%b", obs, 7'b1001011);
    end
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus4.data = (i == 0) ? 4'b1111 : 4'($urandom);
      @(posedge clk); #1;
      obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
      checks++;
      if (obs !== 7'b0001011) begin
        errors++;
        $display("FAIL hold cycle=%0d got=%b want=%b", i, obs, 7'b0001011);
      end
    end
  endtask

  // Random data and random valid gaps; the model keeps the last accepted result.
  task automatic test_random();
    int x;
    int m_com;
    bit m_ovf;
    bit m_zero;
    bit v;
    logic [6:0] obs;
    logic [6:0] want;
    m_com = 0;
    m_ovf = 1'b0;
    m_zero = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = int'($urandom_range(15, 0));
      v = (i == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      bus4.data = 4'(x);
      bus4.in_valid = v;
      if (v) begin
        m_com = ref_neg(x, 4);
        m_ovf = (x == 8);
        m_zero = (m_com == 0);
      end
      @(posedge clk); #1;
      obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
      want = {v, m_ovf, m_zero, 4'(m_com)};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL random i=%0d in=%0d v=%0b got=%b want=%b", i, x, v, obs, want);
      end
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_sweep4();
    int start;
    int x;
    int r;
    logic [6:0] obs;
    logic [6:0] want;
    start = int'($urandom_range(15, 0));
    for (int i = 0; i < 16; i++) begin
      x = (start + i) % 16;
      if (i == 8) begin
        rst = 1'b1;
        bus4.data = 4'(x);
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
        checks++;
        if (obs !== 7'b0010000) begin
          errors++;
          $display("FAIL sweep4_reset got=%b want=%b", obs, 7'b0010000);
        end
      end
      bus4.data = 4'(x);
      bus4.in_valid = 1'b1;
      r = ref_neg(x, 4);
      @(posedge clk); #1;
      obs = {bus4.out_valid, bus4.ovf, bus4.zero, bus4.com_out};
      want = {1'b1, 1'(x == 8), 1'(r == 0), 4'(r)};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL sweep4 in=%0d got=%b want=%b", x, obs, want);
      end
    end
    bus4.in_valid = 1'b0;
  endtask

  task automatic test_sweep8();
    int start;
    int x;
    int r;
    logic [10:0] obs;
    logic [10:0] want;
    start = int'($urandom_range(255, 0));
    for (int i = 0; i < 256; i++) begin
      x = (start + i) % 256;
      if (i == 100) begin
        rst = 1'b1;
        bus8.data = 8'(x);
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        obs = {bus8.out_valid, bus8.ovf, bus8.zero, bus8.com_out};
        checks++;
        if (obs !== 11'b00100000000) begin
          errors++;
          $display("FAIL sweep8_reset got=%b want=%b", obs, 11'b00100000000);
        end
      end
      bus8.data = 8'(x);
      bus8.in_valid = 1'b1;
      r = ref_neg(x, 8);
      @(posedge clk); #1;
      obs = {bus8.out_valid, bus8.ovf, bus8.zero, bus8.com_out};
      want = {1'b1, 1'(x == 128), 1'(r == 0), 8'(r)};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL sweep8 in=%0d got=%b want=%b", x, obs, want);
      end
    end
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep8_valid_drop got=%b want=0", bus8.out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus4.data = '0;
    bus4.in_valid = 1'b0;
    bus8.data = '0;
    bus8.in_valid = 1'b0;
    #2;
    test_reset();
    test_directed();
    test_most_negative();
    test_zero();
    test_hold();
    test_random();
    test_sweep4();
    test_sweep8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/binary_twos_complement.md
# binary_twos_complement

Registered two's-complement negator: each accepted binary word on `data` yields its arithmetic negation (invert all bits, add one) on `com_out` one clock later. It is a leaf datapath block for sign conversion ahead of subtract/accumulate stages. It also flags the one input whose negation is unrepresentable and indicates zero results.

## Interface
- `WIDTH`, default 4: operand and result width in bits, minimum 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `data`  in  WIDTH: binary operand, two's-complement or unsigned pattern.
- `in_valid`  in  1: `data` is accepted on a rising edge where `in_valid`=1.
- `com_out`  out  WIDTH: registered two's complement of the last accepted `data`.
- `out_valid`  out  1: high for exactly one cycle after each accepted input.
- `ovf`  out  1: registered; 1 when the accepted `data` was the most-negative pattern, 1 followed by WIDTH-1 zeros.
- `zero`  out  1: registered; 1 when `com_out` is all zeros.

## Operation
- Result arithmetic: `com_out` = (~`data` + 1) mod 2^WIDTH. The carry out of the MSB is discarded.
- Zero input gives a zero result, and `zero`=1.
- Most-negative input, e.g. 1000 for WIDTH=4:
  - `ovf`=1.
  - Result follows the Configuration section.
- Operation is purely combinational inside; there is no state machine. The only state is the output register set.
- Accept rule:
  - With `in_valid`=1, all three result registers (`com_out`, `ovf`, `zero`) load and `out_valid` is set to 1.
  - With `in_valid`=0, `com_out`, `ovf` and `zero` hold their values and `out_valid` is cleared to 0.
- Back-to-back accepts every cycle are supported. `out_valid` stays high continuously while `in_valid` stays high.

## Timing
- Latency: exactly 1 cycle from the accepting edge to the results on `com_out`/`ovf`/`zero`/`out_valid`.
- Throughput: one word per cycle. There is no backpressure.
- Reset values: `com_out`=0, `out_valid`=0, `ovf`=0, `zero`=1 (it tracks `com_out`=0).
- Reset has priority over `in_valid` on the same edge. An input presented on the reset edge is dropped.
- Reset asserted mid-stream: outputs take their reset values on the next edge, and no stale `out_valid` pulse follows.
- Changes on `data` while `in_valid`=0 have no effect on the outputs.

## Configuration
- `BIN2C_SATURATE_EN` defined: a most-negative input produces the most-positive value, 0 followed by WIDTH-1 ones (0111 for WIDTH=4). `ovf`=1.
- `BIN2C_SATURATE_EN` undefined: a most-negative input wraps to itself (1000 for WIDTH=4). `ovf`=1.
- All other inputs give identical results in both builds.

## Structure
- Shared package `bin2c_pkg`:
  - `BIN2C_DEFAULT_WIDTH` = 4.
  - A function returning the most-negative pattern for a given width.
  - A function returning the most-positive pattern for a given width.
- Sub-module `twos_comp_core`: combinational; computes the negation, overflow detect, saturation mux and zero detect.
- The top level holds only the valid/register logic.

## Test plan
- Reset: assert `rst` for 2 cycles, with `in_valid`=1 and `data`=0011 during reset -> `com_out`=0000, `out_valid`=0, `ovf`=0, `zero`=1 throughout.
- Directed sequence 0011, 0111, 0011, 1011, 0111, 1100, 1011, 1001 with `in_valid`=1 each cycle:
  - Required `com_out`, one cycle later: 1101, 1001, 1101, 0101, 1001, 0100, 0101, 0111.
  - `out_valid`=1 on each of those cycles; `ovf`=0.
- Most-negative input 1000:
  - Default build -> `com_out`=1000, `ovf`=1.
  - Build with `BIN2C_SATURATE_EN` -> `com_out`=0111, `ovf`=1.
- Zero input 0000 -> `com_out`=0000, `zero`=1, `ovf`=0.
- Hold: accept 0101, which gives 1011, then drop `in_valid` and drive `data`=1111 for 3 cycles -> `com_out` stays 1011, `out_valid`=0.
- Exhaustive WIDTH=4 and WIDTH=8 sweep against the reference model (-x) mod 2^WIDTH. A reset pulse mid-sweep must clear the outputs, and the sweep must resume correctly afterwards.
